// File: rtl/riscv_mem_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states, size legality.
package riscv_mem_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    localparam int WAIT_CNT_W = 4;

    // Stores have no unsigned variants; loads accept the five RV32 encodings.
    function automatic logic size_legal(input logic wr, input logic [2:0] size);
        logic legal;
        case (size)
            SZ_B, SZ_H, SZ_W: legal = 1'b1;
            SZ_BU, SZ_HU:     legal = !wr;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store lane merge into the current word, load extract and extension.
// Build option: DMEM_MISALIGN_ERR_EN flags misaligned H/W accesses instead of aligning down.
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wmerged,
    output logic [31:0] rdata,
    output logic        misalign_err
);

    logic [1:0]  lane;
    logic [3:0]  be;
    logic [31:0] wrep;
    logic [31:0] mask;
    logic [31:0] shifted;

    // Without the error option, offending low address bits are simply dropped.
    always_comb begin
        lane         = offset;
        be           = 4'b1111;
        wrep         = wdata;
        misalign_err = 1'b0;
        case (size[1:0])
            2'b00: begin
                be   = 4'b0001 << offset;
                wrep = {4{wdata[7:0]}};
            end
            2'b01: begin
                lane = {offset[1], 1'b0};
                be   = 4'b0011 << lane;
                wrep = {2{wdata[15:0]}};
`ifdef DMEM_MISALIGN_ERR_EN
                misalign_err = offset[0];
`endif
            end
            default: begin
                lane = 2'b00;
`ifdef DMEM_MISALIGN_ERR_EN
                misalign_err = (offset != 2'b00);
`endif
            end
        endcase
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        wmerged = (rword & ~mask) | (wrep & mask);
    end

    assign shifted = rword >> {lane, 3'b000};

    always_comb begin
        rdata = '0;
        case (size)
            SZ_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            SZ_W:    rdata = rword;
            SZ_BU:   rdata = {24'h0, shifted[7:0]};
            SZ_HU:   rdata = {16'h0, shifted[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the MEM stage: one request per handshake, fixed wait states, one response.
// Build option: DMEM_MISALIGN_ERR_EN (handled in dmem_lane_align) rejects misaligned H/W accesses.
//
//  state | meaning
//  IDLE  | ready for a request; accepting captures it
//  WAIT  | counting down wait states, inputs ignored
//  RESP  | one-cycle response strobe, then back to IDLE
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 9,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_size,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    dmem_state_e           state;
    dmem_state_e           state_nxt;
    logic [WAIT_CNT_W-1:0] cnt;
    logic [WAIT_CNT_W-1:0] cnt_nxt;

    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept;
    logic              enter_resp;
    logic              cur_wr;
    logic [ADDR_W-1:0] cur_addr;
    logic [2:0]        cur_size;
    logic [DATA_W-1:0] cur_wdata;
    logic              cur_err;
    logic              misalign_err;
    logic [DATA_W-1:0] rword;
    logic [DATA_W-1:0] wmerged;
    logic [DATA_W-1:0] load_data;

    logic [DATA_W-1:0] mem [DEPTH];

    assign accept = (state == IDLE) && req_valid;

    // With zero wait states the access completes on the accept edge, so use the live request.
    always_comb begin
        if (state == IDLE) begin
            cur_wr    = req_wr;
            cur_addr  = req_addr;
            cur_size  = req_size;
            cur_wdata = req_wdata;
        end else begin
            cur_wr    = wr_q;
            cur_addr  = addr_q;
            cur_size  = size_q;
            cur_wdata = wdata_q;
        end
    end

    assign enter_resp = (accept && (WAIT_CYC == 0)) || ((state == WAIT) && (cnt == '0));
    assign rword      = mem[cur_addr[ADDR_W-1:2]];
    assign cur_err    = !size_legal(cur_wr, cur_size) || misalign_err;

    dmem_lane_align u_align (
        .size         (cur_size),
        .offset       (cur_addr[1:0]),
        .wdata        (cur_wdata),
        .rword        (rword),
        .wmerged      (wmerged),
        .rdata        (load_data),
        .misalign_err (misalign_err)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYC == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = WAIT_CNT_W'(WAIT_CYC - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                wr_q    <= req_wr;
                addr_q  <= req_addr;
                size_q  <= req_size;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                resp_err   <= cur_err;
                resp_rdata <= (cur_wr || cur_err) ? '0 : load_data;
            end
        end
    end

    // Storage is not reset; the reset level gates the write so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && cur_wr && !cur_err) begin
            mem[cur_addr[ADDR_W-1:2]] <= wmerged;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic against a byte-array model.
module tb_dmem_responder;

    localparam int W0 = 1;
    localparam int W1 = 0;
`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    typedef struct packed {
        logic        wr;
        logic [8:0]  addr;
        logic [2:0]  size;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic        req_wr;
    logic [8:0]  req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_err;
    logic [31:0] rdata0;
    logic [31:0] rdata1;

    logic [7:0] mdl [2][512];
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYC(W0)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_wr(req_wr), .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid[0]), .resp_rdata(rdata0), .resp_err(resp_err[0])
    );

    dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYC(W1)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_wr(req_wr), .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid[1]), .resp_rdata(rdata1), .resp_err(resp_err[1])
    );

    // Reference: memory as bytes; an access is a run of 1/2/4 bytes at an aligned base.
    function automatic void model_access(input int k, input logic wr, input logic [8:0] addr,
                                         input logic [2:0] size, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic err);
        int nb;
        int base;
        logic [31:0] v;
        bit legal;
        legal = wr ? (size <= 3'd2) : (size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        rd  = '0;
        err = 1'b0;
        if (!legal) begin
            err = 1'b1;
            return;
        end
        nb   = 1 << size[1:0];
        base = int'(addr);
        if (MIS && (base % nb != 0)) begin
            err = 1'b1;
            return;
        end
        base = base - (base % nb);
        if (wr) begin
            for (int i = 0; i < nb; i++) mdl[k][base+i] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[k][base+i];
            if (nb < 4 && !size[2] && v[8*nb-1])
                for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
            rd = v;
        end
    endfunction

    // One complete transaction; lat counts negedges from accept edge to the strobe (-1 on timeout).
    task automatic do_txn(input int k, input logic wr, input logic [8:0] addr, input logic [2:0] size,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output logic pulse_ok);
        int guard;
        @(negedge clk);
        req_wr = wr; req_addr = addr; req_size = size; req_wdata = wd;
        req_valid[k] = 1'b1;
        guard = 0;
        while (!req_ready[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_wr = 1'($urandom); req_addr = 9'($urandom); req_size = 3'($urandom); req_wdata = $urandom;
        lat = 1;
        while (!resp_valid[k] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid[k]) begin
            lat = -1; rd = 'x; er = 1'bx; pulse_ok = 1'b0;
            return;
        end
        rd = (k == 0) ? rdata0 : rdata1;
        er = resp_err[k];
        @(negedge clk);
        pulse_ok = !resp_valid[k] && req_ready[k];
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 2'b00;
        req_wr = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp += 4;
            if (req_ready[k] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 1", k, req_ready[k]); end
            if (resp_valid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b expected 0", k, resp_valid[k]); end
            if (resp_err[k] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b expected 0", k, resp_err[k]); end
            if (((k == 0) ? rdata0 : rdata1) !== 32'h0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 0", k, (k == 0) ? rdata0 : rdata1); end
        end
        reset = 1'b1;
    endtask

    task automatic test_init();
        logic [31:0] rd, mrd, wd;
        logic er, merr, pok;
        int lat;
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 128; w++) begin
                wd = $urandom;
                model_access(k, 1'b1, 9'(w*4), 3'b010, wd, mrd, merr);
                do_txn(k, 1'b1, 9'(w*4), 3'b010, wd, rd, er, lat, pok);
                n_cmp++;
                if (er !== 1'b0) begin n_fail++; $display("FAIL init_err[%0d] word %0d: got %b expected 0", k, w, er); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, mrd;
        logic er, merr, pok;
        int lat;
        model_access(0, 1'b1, 9'h010, 3'b010, 32'h11223344, mrd, merr);
        do_txn(0, 1'b1, 9'h010, 3'b010, 32'h11223344, rd, er, lat, pok);
        @(negedge clk);
        req_wr = 1'b1; req_addr = 9'h010; req_size = 3'b010; req_wdata = 32'hCAFEF00D;
        req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (resp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid_in_reset: got %b expected 0", resp_valid[0]); end
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_after_release: got %b expected 1", req_ready[0]); end
        repeat (3) begin
            n_cmp++;
            if (resp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid_after_release: got %b expected 0", resp_valid[0]); end
            @(negedge clk);
        end
        model_access(0, 1'b0, 9'h010, 3'b010, 32'h0, mrd, merr);
        do_txn(0, 1'b0, 9'h010, 3'b010, 32'h0, rd, er, lat, pok);
        n_cmp++;
        if (rd !== 32'h11223344) begin n_fail++; $display("FAIL rstmid_old_data: got %h expected %h", rd, 32'h11223344); end
    endtask

    task automatic test_word();
        logic [31:0] rd, mrd;
        logic er, merr, pok;
        int lat;
        model_access(0, 1'b1, 9'h020, 3'b010, 32'hDEADBEEF, mrd, merr);
        do_txn(0, 1'b1, 9'h020, 3'b010, 32'hDEADBEEF, rd, er, lat, pok);
        n_cmp += 2;
        if (er !== 1'b0) begin n_fail++; $display("FAIL word_sw_err: got %b expected 0", er); end
        if (lat != 2) begin n_fail++; $display("FAIL word_sw_latency: got %0d expected 2", lat); end
        model_access(0, 1'b0, 9'h020, 3'b010, 32'h0, mrd, merr);
        do_txn(0, 1'b0, 9'h020, 3'b010, 32'h0, rd, er, lat, pok);
        n_cmp += 4;
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_lw_rdata: got %h expected DEADBEEF", rd); end
        if (er !== 1'b0) begin n_fail++; $display("FAIL word_lw_err: got %b expected 0", er); end
        if (lat != 2) begin n_fail++; $display("FAIL word_lw_latency: got %0d expected 2", lat); end
        if (pok !== 1'b1) begin n_fail++; $display("FAIL word_lw_pulse: got %b expected 1", pok); end
    endtask

    task automatic test_lanes();
        op_t ops [9];
        logic [31:0] rd, mrd;
        logic er, merr, pok;
        int lat;
        ops[0] = '{1'b1, 9'h040, 3'b010, 32'h00000000, 32'h00000000, 1'b0};
        ops[1] = '{1'b1, 9'h043, 3'b000, 32'h00000080, 32'h00000000, 1'b0};
        ops[2] = '{1'b0, 9'h040, 3'b010, 32'h0,        32'h80000000, 1'b0};
        ops[3] = '{1'b0, 9'h043, 3'b000, 32'h0,        32'hFFFFFF80, 1'b0};
        ops[4] = '{1'b0, 9'h043, 3'b100, 32'h0,        32'h00000080, 1'b0};
        ops[5] = '{1'b1, 9'h042, 3'b001, 32'h00008001, 32'h00000000, 1'b0};
        ops[6] = '{1'b0, 9'h042, 3'b001, 32'h0,        32'hFFFF8001, 1'b0};
        ops[7] = '{1'b0, 9'h042, 3'b101, 32'h0,        32'h00008001, 1'b0};
        ops[8] = '{1'b0, 9'h040, 3'b010, 32'h0,        32'h80010000, 1'b0};
        foreach (ops[i]) begin
            model_access(0, ops[i].wr, ops[i].addr, ops[i].size, ops[i].wd, mrd, merr);
            do_txn(0, ops[i].wr, ops[i].addr, ops[i].size, ops[i].wd, rd, er, lat, pok);
            n_cmp += 2;
            if (rd !== ops[i].exp_rd) begin n_fail++; $display("FAIL lanes_rdata op%0d: got %h expected %h", i, rd, ops[i].exp_rd); end
            if (er !== ops[i].exp_err) begin n_fail++; $display("FAIL lanes_err op%0d: got %b expected %b", i, er, ops[i].exp_err); end
        end
    endtask

    task automatic test_errors();
        op_t ops [9];
        logic [31:0] rd, mrd, after_sh;
        logic er, merr, pok;
        int lat;
        after_sh = MIS ? 32'h80010000 : 32'h12340000;
        ops[0] = '{1'b0, 9'h041, 3'b010, 32'h0,        MIS ? 32'h0 : 32'h80010000, MIS};
        ops[1] = '{1'b1, 9'h043, 3'b001, 32'h00001234, 32'h0,    MIS};
        ops[2] = '{1'b0, 9'h040, 3'b010, 32'h0,        after_sh, 1'b0};
        ops[3] = '{1'b1, 9'h040, 3'b100, 32'hFFFFFFFF, 32'h0,    1'b1};
        ops[4] = '{1'b0, 9'h040, 3'b010, 32'h0,        after_sh, 1'b0};
        ops[5] = '{1'b0, 9'h040, 3'b011, 32'h0,        32'h0,    1'b1};
        ops[6] = '{1'b0, 9'h040, 3'b110, 32'h0,        32'h0,    1'b1};
        ops[7] = '{1'b1, 9'h040, 3'b101, 32'hFFFFFFFF, 32'h0,    1'b1};
        ops[8] = '{1'b0, 9'h040, 3'b010, 32'h0,        after_sh, 1'b0};
        foreach (ops[i]) begin
            model_access(0, ops[i].wr, ops[i].addr, ops[i].size, ops[i].wd, mrd, merr);
            do_txn(0, ops[i].wr, ops[i].addr, ops[i].size, ops[i].wd, rd, er, lat, pok);
            n_cmp += 2;
            if (rd !== ops[i].exp_rd) begin n_fail++; $display("FAIL errors_rdata op%0d: got %h expected %h", i, rd, ops[i].exp_rd); end
            if (er !== ops[i].exp_err) begin n_fail++; $display("FAIL errors_err op%0d: got %b expected %b", i, er, ops[i].exp_err); end
        end
    endtask

    // req_valid held high: accepts must be spaced exactly WAIT_CYC+2 cycles apart.
    task automatic test_back_to_back();
        int acc [$];
        int nresp, period;
        for (int k = 0; k < 2; k++) begin
            period = (k == 0) ? W0 + 2 : W1 + 2;
            acc.delete();
            nresp = 0;
            @(negedge clk);
            req_wr = 1'b0; req_addr = 9'h020; req_size = 3'b010; req_wdata = '0;
            req_valid[k] = 1'b1;
            for (int c = 0; c < 30; c++) begin
                if (req_ready[k]) acc.push_back(c);
                if (resp_valid[k]) nresp++;
                @(negedge clk);
            end
            req_valid[k] = 1'b0;
            for (int c = 0; c < 6; c++) begin
                if (resp_valid[k]) nresp++;
                @(negedge clk);
            end
            n_cmp += 2;
            if (acc.size() != (30 + period - 1) / period) begin n_fail++; $display("FAIL b2b_accepts[%0d]: got %0d expected %0d", k, acc.size(), (30 + period - 1) / period); end
            if (nresp != acc.size()) begin n_fail++; $display("FAIL b2b_responses[%0d]: got %0d expected %0d", k, nresp, acc.size()); end
            for (int i = 1; i < acc.size(); i++) begin
                n_cmp++;
                if (acc[i] - acc[i-1] != period) begin n_fail++; $display("FAIL b2b_gap[%0d] #%0d: got %0d expected %0d", k, i, acc[i] - acc[i-1], period); end
            end
        end
    endtask

    task automatic test_wait0();
        logic [31:0] rd, mrd;
        logic er, merr, pok;
        int lat;
        model_access(1, 1'b1, 9'h1F4, 3'b010, 32'h5A5AC3C3, mrd, merr);
        do_txn(1, 1'b1, 9'h1F4, 3'b010, 32'h5A5AC3C3, rd, er, lat, pok);
        n_cmp += 2;
        if (lat != 1) begin n_fail++; $display("FAIL wait0_sw_latency: got %0d expected 1", lat); end
        if (pok !== 1'b1) begin n_fail++; $display("FAIL wait0_sw_pulse: got %b expected 1", pok); end
        model_access(1, 1'b0, 9'h1F5, 3'b000, 32'h0, mrd, merr);
        do_txn(1, 1'b0, 9'h1F5, 3'b000, 32'h0, rd, er, lat, pok);
        n_cmp += 2;
        if (lat != 1) begin n_fail++; $display("FAIL wait0_lb_latency: got %0d expected 1", lat); end
        if (rd !== 32'hFFFFFFC3) begin n_fail++; $display("FAIL wait0_lb_rdata: got %h expected FFFFFFC3", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, wd;
        logic [8:0] addr;
        logic [2:0] size;
        logic wr, er, merr, pok;
        int lat, k;
        for (int n = 0; n < 300; n++) begin
            k    = n % 2;
            wr   = 1'($urandom);
            addr = 9'($urandom);
            size = 3'($urandom_range(0, 7));
            wd   = $urandom;
            model_access(k, wr, addr, size, wd, mrd, merr);
            do_txn(k, wr, addr, size, wd, rd, er, lat, pok);
            n_cmp += 4;
            if (rd !== mrd) begin n_fail++; $display("FAIL rand_rdata #%0d dut%0d wr=%b a=%h s=%b: got %h expected %h", n, k, wr, addr, size, rd, mrd); end
            if (er !== merr) begin n_fail++; $display("FAIL rand_err #%0d dut%0d: got %b expected %b", n, k, er, merr); end
            if (lat != ((k == 0) ? W0 + 1 : W1 + 1)) begin n_fail++; $display("FAIL rand_latency #%0d dut%0d: got %0d expected %0d", n, k, lat, (k == 0) ? W0 + 1 : W1 + 1); end
            if (pok !== 1'b1) begin n_fail++; $display("FAIL rand_pulse #%0d dut%0d: got %b expected 1", n, k, pok); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init();
        test_reset_mid();
        test_word();
        test_lanes();
        test_errors();
        test_back_to_back();
        test_wait0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
